// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transceiver.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } uart_st_e;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: restarts on start (half or full period), then ticks every CLK_DIV cycles.
module uart_bit_timer #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic half,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, lim_q;

  assign tick = (cnt_q == lim_q);

  // After the first (possibly half) period the limit falls back to a full bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= FULL;
    end else if (start) begin
      cnt_q <= '0;
      lim_q <= half ? HALF : FULL;
    end else if (tick) begin
      cnt_q <= '0;
      lim_q <= FULL;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: TX/RX FSMs, 2-flop RX synchroniser and one-entry RX holding register.
module uart_xcvr import uart_pkg::*; #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  // ---------------- transmitter ----------------
  uart_st_e             tx_st_q, tx_st_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic                 tx_par_q, tx_par_d, tx_out_q, tx_out_d;
  logic                 tx_start, tx_tick;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_tmr (
    .clk(clk), .rst_n(rst), .start(tx_start), .half(1'b0), .tick(tx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q  <= ST_IDLE;
      tx_sh_q  <= '0;
      tx_idx_q <= '0;
      tx_par_q <= 1'b0;
      tx_out_q <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_sh_q  <= tx_sh_d;
      tx_idx_q <= tx_idx_d;
      tx_par_q <= tx_par_d;
      tx_out_q <= tx_out_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    tx_par_d = tx_par_q;
    tx_out_d = tx_out_q;
    tx_start = 1'b0;
    case (tx_st_q)
      ST_IDLE: if (tx_valid) begin
        tx_sh_d  = tx_data;
        tx_par_d = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        tx_out_d = 1'b0;
        tx_start = 1'b1;
        tx_st_d  = ST_START;
      end
      ST_START: if (tx_tick) begin
        tx_st_d  = ST_DATA;
        tx_idx_d = '0;
        tx_out_d = tx_sh_q[0];
      end
      ST_DATA: if (tx_tick) begin
        if (tx_idx_q == LAST_D) begin
          tx_st_d  = HAS_PAR ? ST_PAR : ST_STOP;
          tx_out_d = HAS_PAR ? tx_par_q : 1'b1;
          tx_idx_d = '0;
        end else begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_out_d = tx_sh_q[1];
          tx_idx_d = tx_idx_q + IW'(1);
        end
      end
      ST_PAR: if (tx_tick) begin
        tx_st_d  = ST_STOP;
        tx_out_d = 1'b1;
        tx_idx_d = '0;
      end
      ST_STOP: if (tx_tick) begin
        if (tx_idx_q == LAST_S) tx_st_d = ST_IDLE;
        else                    tx_idx_d = tx_idx_q + IW'(1);
      end
      default: tx_st_d = ST_IDLE;
    endcase
  end

  assign tx_ready = (tx_st_q == ST_IDLE);
  assign tx_out   = tx_out_q;

  // ---------------- receiver ----------------
  uart_st_e             rx_st_q, rx_st_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic                 rx_perr_q, rx_perr_d, armed_q, armed_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_start, rx_tick, rx_done, rx_ferr;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_pe_q, rx_fe_q, rx_ovr_q;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_tmr (
    .clk(clk), .rst_n(rst), .start(rx_start), .half(rx_start), .tick(rx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_st_q   <= ST_IDLE;
      rx_sh_q   <= '0;
      rx_idx_q  <= '0;
      rx_perr_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      rx_st_q   <= rx_st_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
      rx_perr_q <= rx_perr_d;
      armed_q   <= armed_d;
    end
  end

  // armed_q drops after a low stop bit so a stuck-low line is not taken as a new start.
  always_comb begin
    rx_st_d   = rx_st_q;
    rx_sh_d   = rx_sh_q;
    rx_idx_d  = rx_idx_q;
    rx_perr_d = rx_perr_q;
    armed_d   = armed_q;
    rx_start  = 1'b0;
    rx_done   = 1'b0;
    rx_ferr   = 1'b0;
    case (rx_st_q)
      ST_IDLE: begin
        if (!armed_q) armed_d = sync2_q;
        else if (!sync2_q) begin
          rx_start = 1'b1;
          rx_st_d  = ST_START;
        end
      end
      ST_START: if (rx_tick) begin
        if (sync2_q) rx_st_d = ST_IDLE;
        else begin
          rx_st_d   = ST_DATA;
          rx_idx_d  = '0;
          rx_perr_d = 1'b0;
        end
      end
      ST_DATA: if (rx_tick) begin
        rx_sh_d = {sync2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_idx_q == LAST_D) rx_st_d = HAS_PAR ? ST_PAR : ST_STOP;
        else                    rx_idx_d = rx_idx_q + IW'(1);
      end
      ST_PAR: if (rx_tick) begin
        rx_perr_d = (PARITY == PAR_ODD) ? ~(^rx_sh_q ^ sync2_q) : (^rx_sh_q ^ sync2_q);
        rx_st_d   = ST_STOP;
      end
      ST_STOP: if (rx_tick) begin
        rx_done = 1'b1;
        rx_ferr = ~sync2_q;
        armed_d = sync2_q;
        rx_st_d = ST_IDLE;
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= rx_sh_q;
          rx_pe_q    <= rx_perr_q;
          rx_fe_q    <= rx_ferr;
          rx_valid_q <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench: an 8N1 instance and an 8E1 instance, both at CLK_DIV=16.
module tb_uart_xcvr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic txv_a = 1'b0, txv_e = 1'b0;
  logic rdy_a = 1'b0, rdy_e = 1'b0;
  logic loop_a = 1'b0, loop_e = 1'b0;
  logic drv_a = 1'b1, drv_e = 1'b1;
  logic rxin_a, rxin_e;
  logic tx_ready_a, tx_out_a, rx_valid_a, pe_a, fe_a, ovr_a;
  logic tx_ready_e, tx_out_e, rx_valid_e, pe_e, fe_e, ovr_e;
  logic [7:0] rx_data_a, rx_data_e;
  int n_chk = 0, n_fail = 0;
  int ovr_cnt, ovr_at;

  always #5 clk = ~clk;

  assign rxin_a = loop_a ? tx_out_a : drv_a;
  assign rxin_e = loop_e ? tx_out_e : drv_e;

  uart_xcvr #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(txv_a), .tx_ready(tx_ready_a),
    .tx_out(tx_out_a), .rx_in(rxin_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rdy_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ovr_a));

  uart_xcvr #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(txv_e), .tx_ready(tx_ready_e),
    .tx_out(tx_out_e), .rx_in(rxin_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_ready(rdy_e), .rx_parity_err(pe_e), .rx_frame_err(fe_e), .rx_overrun(ovr_e));

  // Sends d through the chosen instance in loopback, checking every line cycle,
  // tx_ready timing, the exact rx_valid rise cycle and the received byte.
  task automatic send_check(input logic [7:0] d, input bit e);
    logic [10:0] bits;
    int f, rise;
    logic o, r, v;
    f = e ? 11 : 10;
    rise = 16 * f - 4;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (e) bits[9] = ^d;
    @(posedge clk); #1;
    tx_data = d;
    if (e) txv_e = 1'b1; else txv_a = 1'b1;
    @(posedge clk); #1;
    txv_a = 1'b0; txv_e = 1'b0;
    for (int k = 1; k <= 16 * f; k++) begin
      @(negedge clk);
      o = e ? tx_out_e : tx_out_a;
      r = e ? tx_ready_e : tx_ready_a;
      v = e ? rx_valid_e : rx_valid_a;
      n_chk++;
      if (o !== bits[(k-1)/16]) begin
        n_fail++; $display("FAIL tx_line %h cyc %0d: got %b want %b", d, k, o, bits[(k-1)/16]);
      end
      n_chk++;
      if (r !== 1'b0) begin
        n_fail++; $display("FAIL tx_ready_busy %h cyc %0d: got %b want 0", d, k, r);
      end
      n_chk++;
      if (v !== (k >= rise)) begin
        n_fail++; $display("FAIL rx_valid_latency %h cyc %0d: got %b want %b", d, k, v, k >= rise);
      end
    end
    @(negedge clk);
    r = e ? tx_ready_e : tx_ready_a;
    n_chk++;
    if (r !== 1'b1) begin
      n_fail++; $display("FAIL tx_ready_return %h: got %b want 1", d, r);
    end
    n_chk++;
    if ((e ? rx_data_e : rx_data_a) !== d) begin
      n_fail++; $display("FAIL loop_data: got %h want %h", e ? rx_data_e : rx_data_a, d);
    end
    n_chk++;
    if ((e ? {pe_e, fe_e} : {pe_a, fe_a}) !== 2'b00) begin
      n_fail++; $display("FAIL loop_errs: got %b want 00", e ? {pe_e, fe_e} : {pe_a, fe_a});
    end
  endtask

  // Bench-driven frame on the chosen instance's rx_in; tallies dut_a overrun pulses.
  task automatic drive_frame(input logic [7:0] d, input bit e, input bit use_par,
                             input bit pbit, input bit stop);
    logic [10:0] bits;
    int nb, cyc;
    nb = use_par ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (use_par) begin bits[9] = pbit; bits[10] = stop; end
    else bits[9] = stop;
    ovr_cnt = 0; ovr_at = 0; cyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      if (e) drv_e = bits[i]; else drv_a = bits[i];
      repeat (16) begin
        @(negedge clk);
        cyc++;
        if (ovr_a === 1'b1) begin ovr_cnt++; ovr_at = cyc; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume(input bit e);
    @(posedge clk); #1;
    if (e) rdy_e = 1'b1; else rdy_a = 1'b1;
    @(posedge clk); #1;
    rdy_a = 1'b0; rdy_e = 1'b0;
    @(negedge clk);
    n_chk++;
    if ((e ? rx_valid_e : rx_valid_a) !== 1'b0) begin
      n_fail++; $display("FAIL consume_clears: got %b want 0", e ? rx_valid_e : rx_valid_a);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (tx_out_a !== 1'b1)   begin n_fail++; $display("FAIL rst_tx_out: got %b want 1", tx_out_a); end
    n_chk++; if (tx_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready_a); end
    n_chk++; if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid_a); end
    n_chk++; if (rx_data_a !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data_a); end
    n_chk++; if ({pe_a, fe_a, ovr_a} !== 3'b000) begin n_fail++; $display("FAIL rst_errs: got %b want 000", {pe_a, fe_a, ovr_a}); end
    n_chk++; if (tx_out_e !== 1'b1)   begin n_fail++; $display("FAIL rst_tx_out_e: got %b want 1", tx_out_e); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_loopback_8n1;
    loop_a = 1'b1;
    send_check(8'h55, 1'b0);
    consume(1'b0);
    loop_a = 1'b0;
  endtask

  task automatic test_parity_8e1;
    loop_e = 1'b1;
    send_check(8'hA3, 1'b1);
    consume(1'b1);
    loop_e = 1'b0;
    drive_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++; if (rx_valid_e !== 1'b1) begin n_fail++; $display("FAIL par_valid: got %b want 1", rx_valid_e); end
    n_chk++; if (pe_e !== 1'b1)       begin n_fail++; $display("FAIL par_err: got %b want 1", pe_e); end
    n_chk++; if (rx_data_e !== 8'hA3) begin n_fail++; $display("FAIL par_data: got %h want a3", rx_data_e); end
    n_chk++; if (fe_e !== 1'b0)       begin n_fail++; $display("FAIL par_ferr: got %b want 0", fe_e); end
    consume(1'b1);
  endtask

  task automatic test_glitch;
    @(posedge clk); #1 drv_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 drv_a = 1'b1;
    repeat (200) @(negedge clk);
    n_chk++; if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", rx_valid_a); end
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (rx_valid_a !== 1'b1) begin n_fail++; $display("FAIL glitch_next_valid: got %b want 1", rx_valid_a); end
    n_chk++; if (rx_data_a !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data: got %h want 3c", rx_data_a); end
    consume(1'b0);
  endtask

  task automatic test_frame_err;
    drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (rx_valid_a !== 1'b1) begin n_fail++; $display("FAIL ferr_valid: got %b want 1", rx_valid_a); end
    n_chk++; if (fe_a !== 1'b1)       begin n_fail++; $display("FAIL ferr_flag: got %b want 1", fe_a); end
    n_chk++; if (rx_data_a !== 8'h81) begin n_fail++; $display("FAIL ferr_data: got %h want 81", rx_data_a); end
    consume(1'b0);
    repeat (38) @(posedge clk);
    #1 drv_a = 1'b1;
    repeat (150) @(negedge clk);
    n_chk++; if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL ferr_no_rearm: got %b want 0", rx_valid_a); end
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (rx_data_a !== 8'h5A) begin n_fail++; $display("FAIL ferr_next_data: got %h want 5a", rx_data_a); end
    n_chk++; if (fe_a !== 1'b0)       begin n_fail++; $display("FAIL ferr_next_flag: got %b want 0", fe_a); end
    consume(1'b0);
  endtask

  task automatic test_overrun;
    drive_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (rx_data_a !== 8'h11) begin n_fail++; $display("FAIL ovr_first: got %h want 11", rx_data_a); end
    n_chk++; if (ovr_cnt !== 0)       begin n_fail++; $display("FAIL ovr_none: got %0d want 0", ovr_cnt); end
    drive_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (ovr_cnt !== 1)       begin n_fail++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
    n_chk++; if (ovr_at !== 156)      begin n_fail++; $display("FAIL ovr_cycle: got %0d want 156", ovr_at); end
    n_chk++; if (rx_data_a !== 8'h11) begin n_fail++; $display("FAIL ovr_held: got %h want 11", rx_data_a); end
    n_chk++; if (rx_valid_a !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", rx_valid_a); end
    consume(1'b0);
  endtask

  task automatic test_reset_mid_tx;
    loop_a = 1'b1;
    @(posedge clk); #1 tx_data = 8'hF0; txv_a = 1'b1;
    @(posedge clk); #1 txv_a = 1'b0;
    repeat (88) @(negedge clk);
    n_chk++; if (tx_ready_a !== 1'b0) begin n_fail++; $display("FAIL midtx_busy: got %b want 0", tx_ready_a); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (tx_out_a !== 1'b1)   begin n_fail++; $display("FAIL midtx_async_out: got %b want 1", tx_out_a); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++; if (tx_ready_a !== 1'b1) begin n_fail++; $display("FAIL midtx_ready: got %b want 1", tx_ready_a); end
    n_chk++; if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL midtx_rx_valid: got %b want 0", rx_valid_a); end
    repeat (200) @(negedge clk);
    n_chk++; if (rx_valid_a !== 1'b0) begin n_fail++; $display("FAIL midtx_partial: got %b want 0", rx_valid_a); end
    send_check(8'h0F, 1'b0);
    consume(1'b0);
    loop_a = 1'b0;
  endtask

  initial begin
    test_reset;
    test_loopback_8n1;
    test_parity_8e1;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid_tx;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

Parametrised full-duplex UART transceiver: one transmitter and one receiver sharing a clock, with configurable bit period, data width, parity and stop bits. It replaces the fixed 8N1 `UART` block in loopback and system use. Valid/ready handshakes on both byte sides, a one-entry receive holding register, and per-frame error reporting (parity, framing, overrun) are new.

## Interface
- `CLK_DIV`, 868: clock cycles per bit, ≥ 4 (868 = 115200 baud at 100 MHz).
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter idle; transfer on `tx_valid && tx_ready`.
- `tx_out` out 1: serial line, idles high.
- `rx_in` in 1: serial line, asynchronous to `clk`.
- `rx_data` out DATA_BITS: received byte.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer takes `rx_data` on `rx_valid && rx_ready`.
- `rx_parity_err` out 1: parity mismatch on the held frame; valid with `rx_valid`.
- `rx_frame_err` out 1: stop bit sampled low on the held frame; valid with `rx_valid`.
- `rx_overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Frame format:** start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
  - Frame length in bits: F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
  - Odd parity: the data bits plus the parity bit contain an odd number of ones. Even parity: an even number.
- **TX states:** IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
  - Each state holds for CLK_DIV cycles per bit.
  - `tx_data` is captured in a shift register at the handshake.
- **RX input:** `rx_in` passes through a 2-flop synchroniser; both flops reset to 1.
- **RX states:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: wait for a falling edge on the synchronised line.
  - START: resample after CLK_DIV/2 cycles (integer divide). If the line is high, treat it as a glitch and return to IDLE.
  - Later bits are sampled every CLK_DIV cycles, at mid-bit.
  - Only the first stop bit is checked.
- **RX completion:** after the stop-bit sample, load `rx_data` and the error flags, set `rx_valid`, and return to IDLE.
  - If the stop bit was low, IDLE waits for the line to go high before rearming.
- **Holding register:** `rx_valid` stays high until the handshake.
  - A handshake in the same cycle as a completion: the new frame loads and `rx_valid` stays 1.
  - A completion while the register is full and not being consumed: the new frame is dropped, `rx_overrun` pulses, and the held data is unchanged.
- **Errors:** error frames are still delivered; software decides whether to discard them.

## Timing
- **Reset values:** `tx_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, all error outputs 0, both FSMs in IDLE.
- **Reset mid-frame:** the frame is aborted. `tx_out` returns high asynchronously. A partial RX frame is discarded.
- **TX handshake:** at handshake edge T, `tx_ready` falls and `tx_out` goes low at T+1.
  - Bit k occupies cycles T+1+k·CLK_DIV to T+(k+1)·CLK_DIV.
  - `tx_ready` rises at T+F·CLK_DIV+1, so back-to-back frames are gapless.
  - `tx_valid` while `tx_ready`=0 is ignored.
- **RX latency:** a line edge is seen 2 cycles later (synchroniser). `rx_valid` rises 1 cycle after the stop-bit sample edge.
- **Bit counters:** width clog2(CLK_DIV); counter wraps from CLK_DIV−1 to 0.
- **Bit index:** width clog2(DATA_BITS+1).

## Structure
- Package `uart_pkg` holds:
  - parity constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2;
  - the shared TX/RX state encodings (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PAR`, `ST_STOP`).
- Sub-module `uart_bit_timer` (CLK_DIV parameter; inputs `start`, `half`; output `tick`) is instantiated once in TX and once in RX.
- TX FSM, RX FSM, synchroniser and holding register live in `uart_xcvr`.

## Test plan
All scenarios use CLK_DIV=16.
- **8N1 loopback:** `tx_out`→`rx_in`, send 0x55.
  - Frame is 160 cycles, line reads 0,1,0,1,0,1,0,1,0,1.
  - `rx_data`=0x55, `rx_valid`=1, no error flags; `tx_ready` back high at cycle 161.
- **8E1 parity:** send 0xA3 (four ones), so the parity bit is 0.
  - Receiver reports no error.
  - A bench-driven frame 0xA3 with parity bit 1 gives `rx_parity_err`=1 alongside `rx_valid`.
- **Glitch rejection:** drive `rx_in` low for 4 cycles, then high.
  - No `rx_valid`; RX returns to IDLE.
  - A following valid 0x3C frame is received correctly.
- **Framing error:** frame 0x81 with stop bit driven low, line held low for 40 more cycles.
  - `rx_frame_err`=1 with `rx_valid`.
  - No further frame until the line has returned high.
- **Overrun:** `rx_ready`=0, frames 0x11 then 0x22 received.
  - `rx_data` stays 0x11 and `rx_overrun` pulses once at the second stop sample.
  - Asserting `rx_ready` then clears `rx_valid`.
- **Reset mid-TX:** assert `rst`=0 during data bit 4 of 0xF0.
  - `tx_out`=1 immediately; `tx_ready`=1 and `rx_valid`=0 after release.
  - The next send of 0x0F completes normally.
